md_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle datapath.
- Sits directly downstream of the control unit. It starts on the control unit's MdCtrl pulse and consumes the A/B register operands.
- Produces the HI/LO registers read by the DataSrc mux, and a divide-by-zero flag consumed by the control unit's exception path (ExcptCtrl).

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_iter_step.sv | 45 ++++
 rtl/md_unit.sv | 177 +++++++++++++++++
 tb/tb_md_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the FSM state encoding, operation codes and iteration constants.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = MD_WIDTH;
  localparam int MD_CNT_W = 6;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    ZERO = 3'd3,
    DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// Accumulator layout: upper WIDTH+2 bits are the partial product / partial
// remainder, lower WIDTH bits hold the multiplier (shifted out) or the
// dividend (shifted out) with quotient bits shifted in.
module md_iter_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic [2*WIDTH+1:0] acc,
  input  logic [WIDTH:0]     operand,
  input  logic               md_op,
  output logic [2*WIDTH+1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH+1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] shl_upper;
  logic [WIDTH+2:0] diff;

  // Shift-add for multiply, restoring subtract for divide.
  always_comb begin
    upper     = acc[2*WIDTH+1:WIDTH];
    lower     = acc[WIDTH-1:0];
    sum       = upper;
    shl_upper = '0;
    diff      = '0;
    q_bit     = 1'b0;
    acc_next  = acc;
    if (md_op == MD_OP_MULT) begin
      if (lower[0]) begin
        sum = upper + {1'b0, operand};
      end
      acc_next = {1'b0, sum, lower[WIDTH-1:1]};
    end else begin
      shl_upper = {upper[WIDTH:0], lower[WIDTH-1]};
      diff      = {1'b0, shl_upper} - {2'b00, operand};
      q_bit     = ~diff[WIDTH+2];
      acc_next  = {(q_bit ? diff[WIDTH+1:0] : shl_upper), lower[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative signed multiply/divide unit.
// Started by MdCtrl from the control unit; results land in Hi/Lo after
// WIDTH shift/subtract iterations plus a sign-fix cycle. Divide by zero
// short-circuits to DONE with div_zero pulsed and Hi/Lo left untouched.
// Optional macro MD_UNSIGNED_EN enables multu/divu via md_unsigned.
//
// state | meaning
// IDLE  | waiting for MdCtrl
// RUN   | one multiply/divide iteration per cycle
// FIX   | apply result signs, write Hi/Lo
// ZERO  | divisor was zero, no result written
// DONE  | one-cycle completion pulse
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MdCtrl,
  input  logic             md_op,
  input  logic             md_unsigned,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_zero
);

  localparam logic [MD_CNT_W-1:0] LAST_ITER = MD_CNT_W'(WIDTH - 1);

  md_state_t            state, state_next;
  logic [MD_CNT_W-1:0]  cnt;
  logic [2*WIDTH+1:0]   acc, acc_next;
  logic [WIDTH:0]       opnd;
  logic                 op_r, neg_q, neg_r, dz_r;
  logic                 q_bit;

  logic                 signed_mode;
  logic                 sign_a, sign_b;
  logic [WIDTH:0]       mag_a, mag_b;
  logic                 zero_div;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic                 unused_bits;

`ifdef MD_UNSIGNED_EN
  assign signed_mode = ~md_unsigned;
`else
  logic unused_unsigned;
  assign signed_mode     = 1'b1;
  assign unused_unsigned = md_unsigned;
`endif

  // Magnitudes are kept WIDTH+1 bits wide so -2^(WIDTH-1) is representable.
  always_comb begin
    sign_a   = signed_mode & a_in[WIDTH-1];
    sign_b   = signed_mode & b_in[WIDTH-1];
    mag_a    = sign_a ? ({1'b0, ~a_in} + (WIDTH+1)'(1)) : {1'b0, a_in};
    mag_b    = sign_b ? ({1'b0, ~b_in} + (WIDTH+1)'(1)) : {1'b0, b_in};
    zero_div = (md_op == MD_OP_DIV) && (b_in == '0);
  end

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .md_op    (op_r),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  // Sign fix on the final magnitudes; -2^31 / -1 wraps naturally here.
  always_comb begin
    prod_fix = neg_q ? (~acc[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc[2*WIDTH-1:0];
    quot_fix = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
  end

  // Quotient bits already live in acc; the carry-guard bits never hold result data.
  assign unused_bits = ^{q_bit, acc[2*WIDTH+1:2*WIDTH]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    div_zero   = 1'b0;
    case (state)
      IDLE: begin
        if (MdCtrl) begin
          state_next = zero_div ? ZERO : RUN;
        end
      end
      RUN: begin
        md_busy = 1'b1;
        if (cnt == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX: begin
        md_busy    = 1'b1;
        state_next = DONE;
      end
      ZERO: begin
        md_busy    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        md_done    = 1'b1;
        div_zero   = dz_r;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, and Hi/Lo write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      op_r  <= MD_OP_MULT;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_r  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MdCtrl) begin
            cnt   <= '0;
            op_r  <= md_op;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            dz_r  <= zero_div;
            if (md_op == MD_OP_DIV) begin
              opnd <= mag_b;
              acc  <= {{(WIDTH+2){1'b0}}, mag_a[WIDTH-1:0]};
            end else begin
              opnd <= mag_a;
              acc  <= {{(WIDTH+2){1'b0}}, mag_b[WIDTH-1:0]};
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + MD_CNT_W'(1);
        end
        FIX: begin
          if (op_r == MD_OP_DIV) begin
            Hi <= rem_fix;
            Lo <= quot_fix;
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: latency, busy window, div_zero pulse,
// ignored restarts, mid-operation reset, and signed corner cases.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         MdCtrl;
  logic         md_op;
  logic         md_unsigned;
  logic [W-1:0] a_in, b_in;
  logic [W-1:0] Hi, Lo;
  logic         md_busy, md_done, div_zero;

  int chk_cnt = 0;
  int err_cnt = 0;
  int done_cyc, done_num, busy_err, dz_err;

  md_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .MdCtrl      (MdCtrl),
    .md_op       (md_op),
    .md_unsigned (md_unsigned),
    .a_in        (a_in),
    .b_in        (b_in),
    .Hi          (Hi),
    .Lo          (Lo),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one operation and observes 40 cycles after the sampling edge.
  // k counts cycles after the edge that sampled MdCtrl (k=1 is the first).
  task automatic run_op(input logic op, input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input logic zero_exp, input int inj_k, input int rst_k);
    int   exp_done;
    logic busy_exp, dz_exp;
    exp_done = (rst_k != 0) ? 0 : lat;
    done_cyc = 0;
    done_num = 0;
    busy_err = 0;
    dz_err   = 0;
    @(negedge clk);
    MdCtrl      = 1'b1;
    md_op       = op;
    md_unsigned = uns;
    a_in        = a;
    b_in        = b;
    @(posedge clk);
    #1;
    MdCtrl = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (md_done === 1'b1) begin
        done_num++;
        if (done_cyc == 0) done_cyc = k;
      end
      busy_exp = (k < lat) && ((rst_k == 0) || (k <= rst_k));
      if (md_busy !== busy_exp) busy_err++;
      dz_exp = zero_exp && (k == exp_done);
      if (div_zero !== dz_exp) dz_err++;
      if (k == inj_k) begin
        MdCtrl = 1'b1;
        md_op  = ~op;
        a_in   = 32'h0000_0005;
        b_in   = 32'h0000_0003;
      end else begin
        MdCtrl = 1'b0;
      end
      reset = (k == rst_k);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic op, input logic uns,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input logic zero_exp, input int inj_k, input int rst_k,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    run_op(op, uns, a, b, lat, zero_exp, inj_k, rst_k);
    check_val({tag, ".done_cycle"}, done_cyc, (rst_k != 0) ? 0 : lat);
    check_val({tag, ".done_count"}, done_num, (rst_k != 0) ? 0 : 1);
    check_val({tag, ".busy_errs"}, busy_err, 0);
    check_val({tag, ".dz_errs"}, dz_err, 0);
    check_val({tag, ".hi"}, Hi, exp_hi);
    check_val({tag, ".lo"}, Lo, exp_lo);
  endtask

  initial begin
    reset       = 1'b1;
    MdCtrl      = 1'b0;
    md_op       = 1'b0;
    md_unsigned = 1'b0;
    a_in        = '0;
    b_in        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.hi", Hi, 0);
    check_val("rst.lo", Lo, 0);
    check_val("rst.busy", md_busy, 0);
    check_val("rst.done", md_done, 0);
    check_val("rst.dz", div_zero, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op("mul_7_m3", MD_OP_MULT, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 34, 1'b0, 0, 0,
          32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mul_min_min", MD_OP_MULT, 1'b0, 32'h8000_0000, 32'h8000_0000, 34, 1'b0, 0, 0,
          32'h4000_0000, 32'h0000_0000);
    do_op("mul_restart_ign", MD_OP_MULT, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 34, 1'b0, 5, 0,
          32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("div_100_7", MD_OP_DIV, 1'b0, 32'd100, 32'd7, 34, 1'b0, 0, 0,
          32'd2, 32'd14);
    do_op("div_by_zero", MD_OP_DIV, 1'b0, 32'd5, 32'd0, 2, 1'b1, 0, 0,
          32'd2, 32'd14);
    do_op("div_m7_2", MD_OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 34, 1'b0, 0, 0,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf", MD_OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0, 0, 0,
          32'h0000_0000, 32'h8000_0000);
    do_op("div_done_ign", MD_OP_DIV, 1'b0, 32'd100, 32'd7, 34, 1'b0, 34, 0,
          32'd2, 32'd14);
    do_op("mid_reset", MD_OP_MULT, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 34, 1'b0, 0, 10,
          32'h0000_0000, 32'h0000_0000);
`ifdef MD_UNSIGNED_EN
    do_op("multu", MD_OP_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2, 34, 1'b0, 0, 0,
          32'h0000_0001, 32'hFFFF_FFFE);
`else
    do_op("mult_uns_ignored", MD_OP_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2, 34, 1'b0, 0, 0,
          32'hFFFF_FFFF, 32'hFFFF_FFFE);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
